// File: rtl/salsa_ks_xor.sv
// ---------------------------------------------------------------------------
// salsa_ks_xor
//   Keystream combiner behind the Salsa20 core. Holds one 512-bit keystream
//   block, XORs it word by word into the data stream under valid/ready
//   handshakes and owns the 64-bit block counter that upstream uses to build
//   the next core input. Encryption and decryption are the same operation.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   msg_start         abort message: counter to 0, drop buffered block
//   ks_block[512:1]   keystream block, word i = ks_block[DATA_W*(i+1):DATA_W*i+1]
//   ks_valid/ks_ready keystream block handshake (ready while buffer empty)
//   blk_cnt           counter value upstream must use for the next block
//   in_data/in_last   input word and end-of-message flag
//   in_valid/in_ready input word handshake
//   out_data/out_last registered XOR result and copy of in_last
//   out_valid/out_ready output word handshake
//   ctr_wrap          sticky flag: blk_cnt rolled over (keystream reuse)
// ---------------------------------------------------------------------------
module salsa_ks_xor #(
   parameter int DATA_W = 32,
   parameter int CTR_W  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              msg_start,
   input  logic [512:1]      ks_block,
   input  logic              ks_valid,
   output logic              ks_ready,
   output logic [CTR_W-1:0]  blk_cnt,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              ctr_wrap
);

   localparam int NW    = 512 / DATA_W;
   localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [DATA_W-1:0] r_ks_word [NW];
   logic [IDX_W-1:0]  r_idx;
   logic [CTR_W-1:0]  r_blk_cnt;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_last;
   logic              r_out_valid;
   logic              r_ctr_wrap;

   logic              w_ks_ready;
   logic              w_in_ready;
   logic              w_ks_xfer;
   logic              w_in_xfer;
   logic              w_exhaust;
   logic [DATA_W-1:0] w_ks_sel;

   assign w_ks_sel = r_ks_word[r_idx];

   // Handshake decode and next state. msg_start overrides everything: the
   // block port reads as ready but nothing is accepted in that cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_ks_ready  = 1'b0;
      w_in_ready  = 1'b0;
      w_ks_xfer   = 1'b0;
      w_in_xfer   = 1'b0;
      w_exhaust   = 1'b0;
      if (msg_start) begin
         w_ks_ready  = 1'b1;
         w_state_nxt = S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: begin
               w_ks_ready = 1'b1;
               w_ks_xfer  = ks_valid;
               if (ks_valid) begin
                  w_state_nxt = S_FULL;
               end
            end
            S_FULL: begin
               // single output register without skid buffer
               w_in_ready = !r_out_valid || out_ready;
               w_in_xfer  = in_valid && w_in_ready;
               // a message end also retires the block: no message starts mid-block
               w_exhaust  = w_in_xfer && ((r_idx == LAST_IDX) || in_last);
               if (w_exhaust) begin
                  w_state_nxt = S_EMPTY;
               end
            end
            default: w_state_nxt = S_EMPTY;
         endcase
      end
   end

   // Stage p0 -> buffer: keystream words captured on block acceptance.
   always_ff @(posedge clk) begin
      if (w_ks_xfer) begin
         for (int i = 0; i < NW; i++) begin
            r_ks_word[i] <= ks_block[DATA_W*i+1 +: DATA_W];
         end
      end
   end

   // Stage buffer -> p1: word index, counter, output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_EMPTY;
         r_idx       <= '0;
         r_blk_cnt   <= '0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
         r_ctr_wrap  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (msg_start) begin
            r_idx       <= '0;
            r_blk_cnt   <= '0;
            r_out_valid <= 1'b0;
         end else begin
            if (w_ks_xfer) begin
               r_idx <= '0;
            end else if (w_exhaust) begin
               r_idx     <= '0;
               r_blk_cnt <= r_blk_cnt + CTR_W'(1);
               // sticky until reset; msg_start deliberately leaves it set
               if (&r_blk_cnt) begin
                  r_ctr_wrap <= 1'b1;
               end
            end else if (w_in_xfer) begin
               r_idx <= r_idx + IDX_W'(1);
            end

            if (w_in_xfer) begin
               r_out_data  <= in_data ^ w_ks_sel;
               r_out_last  <= in_last;
               r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
               r_out_valid <= 1'b0;
            end
         end
      end
   end

   assign ks_ready  = w_ks_ready;
   assign in_ready  = w_in_ready;
   assign blk_cnt   = r_blk_cnt;
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign out_valid = r_out_valid;
   assign ctr_wrap  = r_ctr_wrap;

endmodule

// File: tb/tb_salsa_ks_xor.sv
// ---------------------------------------------------------------------------
// tb_salsa_ks_xor
//   Bench for salsa_ks_xor. A message-level model (keystream block chosen by
//   block counter, word chosen by position within the message) predicts every
//   output word, the counter and both ready signals. Directed sequences pin
//   the model with literal values; a second instance with a 4-bit counter
//   exercises counter wrap.
// ---------------------------------------------------------------------------
module tb_salsa_ks_xor;

   localparam int DW = 32;
   localparam int NW = 512 / DW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance
   logic          rst_n;
   logic          msg_start;
   logic [512:1]  ks_block;
   logic          ks_valid;
   logic          ks_ready;
   logic [63:0]   blk_cnt;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_valid;
   logic          out_ready;
   logic          ctr_wrap;

   // narrow-counter instance
   logic          msg_start2;
   logic [512:1]  ks_block2;
   logic          ks_valid2;
   logic          ks_ready2;
   logic [3:0]    blk_cnt2;
   logic [DW-1:0] in_data2;
   logic          in_last2;
   logic          in_valid2;
   logic          in_ready2;
   logic [DW-1:0] out_data2;
   logic          out_last2;
   logic          out_valid2;
   logic          out_ready2;
   logic          ctr_wrap2;

   int ks_mode;
   int ks_pct;
   int or_pct;
   int n_tot = 0;
   int n_bad = 0;

   salsa_ks_xor #(.DATA_W(DW), .CTR_W(64)) dut (
      .clk(clk), .rst_n(rst_n), .msg_start(msg_start),
      .ks_block(ks_block), .ks_valid(ks_valid), .ks_ready(ks_ready),
      .blk_cnt(blk_cnt),
      .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
      .ctr_wrap(ctr_wrap)
   );

   salsa_ks_xor #(.DATA_W(DW), .CTR_W(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .msg_start(msg_start2),
      .ks_block(ks_block2), .ks_valid(ks_valid2), .ks_ready(ks_ready2),
      .blk_cnt(blk_cnt2),
      .in_data(in_data2), .in_last(in_last2), .in_valid(in_valid2), .in_ready(in_ready2),
      .out_data(out_data2), .out_last(out_last2), .out_valid(out_valid2), .out_ready(out_ready2),
      .ctr_wrap(ctr_wrap2)
   );

   // keystream word w of the block for counter c
   function automatic logic [31:0] ks_word(input int mode, input logic [63:0] c, input int w);
      logic [31:0] wv;
      wv = 32'(w);
      case (mode)
         0:       ks_word = 32'h0;
         1:       ks_word = wv * 32'h0101_0101;
         default: ks_word = (c[31:0] * 32'h9E37_79B9) ^ c[63:32] ^ (wv * 32'h0100_0193) ^ 32'h5A17_0000;
      endcase
   endfunction

   // upstream core: always presents the block for the current counter
   always_comb begin
      ks_block = '0;
      for (int w = 0; w < NW; w++) begin
         ks_block[DW*w+1 +: DW] = ks_word(ks_mode, blk_cnt, w);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // environment: random ks_valid / out_ready, applied after the driver
   initial begin
      ks_valid  = 1'b0;
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         ks_valid  = ($urandom_range(0, 99) < ks_pct);
         out_ready = ($urandom_range(0, 99) < or_pct);
      end
   end

   // ---------------- behavioural model + compare process ----------------
   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } exp_t;

   exp_t        exp_q[$];
   int          m_k;       // words accepted so far in current message
   logic [63:0] m_base;    // counter value at start of current message
   bit          m_has;     // a keystream block is held
   bit          m_wrap;
   logic [31:0] m_ks [NW];

   always @(negedge clk) begin
      logic [63:0] cnt_now;
      bit          e_ks_rdy;
      bit          e_in_rdy;
      int          wi;
      exp_t        e;
      if (!rst_n) begin
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_out_data",  64'(out_data),  64'd0);
         chk("rst_out_last",  64'(out_last),  64'd0);
         chk("rst_blk_cnt",   blk_cnt,        64'd0);
         chk("rst_ctr_wrap",  64'(ctr_wrap),  64'd0);
         chk("rst_ks_ready",  64'(ks_ready),  64'd1);
         chk("rst_in_ready",  64'(in_ready),  64'd0);
         exp_q.delete();
         m_k = 0; m_base = '0; m_has = 0; m_wrap = 0;
      end else begin
         cnt_now  = m_base + 64'(m_k / NW);
         e_ks_rdy = !m_has || msg_start;
         e_in_rdy = m_has && !msg_start && ((exp_q.size() == 0) || out_ready);
         chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         chk("blk_cnt",   blk_cnt,        cnt_now);
         chk("ks_ready",  64'(ks_ready),  64'(e_ks_rdy));
         chk("in_ready",  64'(in_ready),  64'(e_in_rdy));
         chk("ctr_wrap",  64'(ctr_wrap),  64'(m_wrap));
         if (out_valid && out_ready && exp_q.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(exp_q[0].d));
            chk("out_last", 64'(out_last), 64'(exp_q[0].l));
            void'(exp_q.pop_front());
         end
         if (msg_start) begin
            exp_q.delete();
            m_k = 0; m_base = '0; m_has = 0;
         end else if (ks_valid && e_ks_rdy) begin
            m_has = 1;
            for (int w = 0; w < NW; w++) m_ks[w] = ks_word(ks_mode, cnt_now, w);
         end else if (in_valid && e_in_rdy) begin
            wi  = m_k % NW;
            e.d = in_data ^ m_ks[wi];
            e.l = in_last;
            exp_q.push_back(e);
            m_k++;
            if (in_last || (m_k % NW == 0)) begin
               m_has = 0;
               if (cnt_now == '1) m_wrap = 1;
            end
            if (in_last) begin
               m_base = m_base + 64'((m_k + NW - 1) / NW);
               m_k    = 0;
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic send(input logic [31:0] d, input logic l);
      bit got;
      int n;
      got = 0; n = 0;
      in_valid = 1'b1; in_data = d; in_last = l;
      while (!got && n < 200) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk("send_accepted", 64'(got), 64'd1);
      chk("send_latency_valid", 64'(out_valid), 64'd1);
      chk("send_out_last", 64'(out_last), 64'(l));
   endtask

   task automatic send2(input logic [31:0] d);
      bit got;
      int n;
      got = 0; n = 0;
      in_valid2 = 1'b1; in_data2 = d; in_last2 = 1'b1;
      while (!got && n < 200) begin
         @(negedge clk);
         got = in_ready2;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid2 = 1'b0;
      chk("send2_accepted", 64'(got), 64'd1);
   endtask

   initial begin
      rst_n = 1'b1; msg_start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      ks_mode = 0; ks_pct = 100; or_pct = 100;
      msg_start2 = 1'b0; ks_block2 = '0; ks_valid2 = 1'b1; in_data2 = '0;
      in_last2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("init_blk_cnt", blk_cnt, 64'd0);
      chk("init_out_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b1;

      // 1: all-zero keystream passes data through, counter steps after word 15
      for (int i = 0; i < 16; i++) begin
         if (i == 15) begin
            chk("t1_cnt_before", blk_cnt, 64'd0);
            ks_pct = 0;
         end
         send(32'hA5A5_A5A5, 1'b0);
         chk("t1_out", 64'(out_data), 64'h0000_0000_A5A5_A5A5);
      end
      chk("t1_cnt_after", blk_cnt, 64'd1);
      ks_mode = 1; ks_pct = 100;

      // 2: word i = 0x01010101*i
      for (int i = 0; i < 16; i++) begin
         send(32'(i), 1'b0);
         chk("t2_out", 64'(out_data), 64'((32'h0101_0101 * 32'(i)) ^ 32'(i)));
         if (i == 5)  chk("t2_w5_lit",  64'(out_data), 64'h0505_0500);
         if (i == 15) chk("t2_w15_lit", 64'(out_data), 64'h0F0F_0F00);
      end
      chk("t2_cnt", blk_cnt, 64'd2);

      // 3: in_last on word 4 retires the block
      for (int i = 0; i < 5; i++) begin
         send(32'(i), (i == 4));
         chk("t3_out", 64'(out_data), 64'((32'h0101_0101 * 32'(i)) ^ 32'(i)));
      end
      chk("t3_cnt", blk_cnt, 64'd3);
      chk("t3_ks_ready", 64'(ks_ready), 64'd1);
      chk("t3_in_ready", 64'(in_ready), 64'd0);
      send(32'h0000_1234, 1'b0);
      chk("t3_restart_w0", 64'(out_data), 64'h0000_1234);

      // 4: downstream stall holds the output and blocks input
      for (int i = 1; i < 4; i++) send(32'(i), 1'b0);
      send(32'h0, 1'b0);
      chk("t4_w4", 64'(out_data), 64'h0404_0404);
      or_pct = 0;
      in_valid = 1'b1; in_data = 32'd5;
      repeat (5) begin
         @(negedge clk);
         chk("t4_in_ready", 64'(in_ready), 64'd0);
         chk("t4_hold_valid", 64'(out_valid), 64'd1);
         chk("t4_hold_data", 64'(out_data), 64'h0404_0404);
      end
      or_pct = 100;
      send(32'd5, 1'b0);
      chk("t4_w5", 64'(out_data), 64'h0505_0500);
      send(32'd9, 1'b1);
      chk("t4_w6", 64'(out_data), 64'h0606_060F);
      chk("t4_cnt", blk_cnt, 64'd4);

      // randomized traffic
      @(posedge clk); #1;
      ks_mode = 2; msg_start = 1'b1; ks_pct = 60; or_pct = 70;
      @(posedge clk); #1;
      msg_start = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         in_valid  = ($urandom_range(0, 99) < 70);
         in_data   = $urandom;
         in_last   = ($urandom_range(0, 99) < 3);
         msg_start = ($urandom_range(0, 299) == 0);
         if (c % 500 == 0) begin
            ks_pct = $urandom_range(20, 100);
            or_pct = $urandom_range(20, 100);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0; msg_start = 1'b0;

      // 5: counter wrap on the 4-bit instance
      for (int k = 0; k < 16; k++) begin
         send2(32'hC0DE_0000 + 32'(k));
         chk("w_out", 64'(out_data2), 64'(32'hC0DE_0000 + 32'(k)));
         chk("w_last", 64'(out_last2), 64'd1);
         if (k == 14) begin
            chk("w_cnt_15", 64'(blk_cnt2), 64'd15);
            chk("w_nowrap", 64'(ctr_wrap2), 64'd0);
         end
      end
      chk("w_cnt_0", 64'(blk_cnt2), 64'd0);
      chk("w_wrap", 64'(ctr_wrap2), 64'd1);
      msg_start2 = 1'b1;
      @(posedge clk); #1;
      msg_start2 = 1'b0;
      chk("w_wrap_after_start", 64'(ctr_wrap2), 64'd1);
      chk("w_cnt_after_start", 64'(blk_cnt2), 64'd0);

      // 6: msg_start at idx 7 with both inputs valid, then async reset
      @(posedge clk); #1;
      ks_pct = 0; ks_mode = 1; or_pct = 100; msg_start = 1'b1;
      @(posedge clk); #1;
      msg_start = 1'b0; ks_pct = 100;
      for (int i = 0; i < 7; i++) send(32'(i), 1'b0);
      in_valid = 1'b1; in_data = 32'd7; in_last = 1'b0; msg_start = 1'b1;
      @(negedge clk);
      chk("t6_ks_ready", 64'(ks_ready), 64'd1);
      chk("t6_in_ready", 64'(in_ready), 64'd0);
      chk("t6_ks_valid", 64'(ks_valid), 64'd1);
      @(posedge clk); #1;
      msg_start = 1'b0; in_valid = 1'b0;
      chk("t6_out_valid", 64'(out_valid), 64'd0);
      chk("t6_cnt", blk_cnt, 64'd0);
      chk("t6_ks_ready_after", 64'(ks_ready), 64'd1);
      send(32'd0, 1'b0);
      send(32'd0, 1'b0);
      send(32'd0, 1'b1);
      chk("t6_pre_rst_data", 64'(out_data), 64'h0202_0202);
      chk("t6_pre_rst_cnt", blk_cnt, 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_arst_out_valid", 64'(out_valid), 64'd0);
      chk("t6_arst_out_data", 64'(out_data), 64'd0);
      chk("t6_arst_out_last", 64'(out_last), 64'd0);
      chk("t6_arst_blk_cnt", blk_cnt, 64'd0);
      chk("t6_arst_ks_ready", 64'(ks_ready), 64'd1);
      chk("t6_arst_in_ready", 64'(in_ready), 64'd0);
      chk("t6_arst_wrap2", 64'(ctr_wrap2), 64'd0);
      chk("t6_arst_cnt2", 64'(blk_cnt2), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
